// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris input front end: piece codes, LFSR/rotation
// widths, button indices and the LFSR/piece helper functions.
package tetris_pkg;

    localparam int LFSR_W  = 8;
    localparam int ROT_W   = 2;
    localparam int PIECE_W = 3;
    localparam int NUM_BTN = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 8'hE1;

    // Bit positions of the buttons in the packed button/pulse vectors.
    localparam int BTN_DOWN   = 3;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_ROTATE = 0;

    typedef enum logic [PIECE_W-1:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_Z = 3'd3,
        PIECE_S = 3'd4,
        PIECE_L = 3'd5,
        PIECE_J = 3'd6
    } piece_t;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form, shifting left.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Code 7 is not a piece; fold it onto O.
    function automatic piece_t piece_from_bits(input logic [PIECE_W-1:0] b);
        return (b == 3'b111) ? PIECE_O : piece_t'(b);
    endfunction

endpackage

// File: rtl/tetris_input_frontend_btn_debounce.sv
// One push-button conditioner: two-flop synchroniser, debounce, press pulse and,
// when TETRIS_INPUT_AUTO_REPEAT_EN is defined, hold-to-repeat pulses.
module btn_debounce
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
    ,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    flush;
    logic          stable;
    logic          stable_d;
    logic          blocked;
    logic [CW-1:0] cnt;
    logic          press;
    logic          fire;

    // A level that was stable-high when reset hit keeps the button blocked until
    // a debounced release is seen; flush waits for the synchroniser to refill.
    assign press = stable & ~stable_d & ~blocked;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            flush    <= 2'b00;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            blocked  <= blocked | stable;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            flush    <= {flush[0], 1'b1};
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (flush[1] && !stable && !sync2) begin
                blocked <= 1'b0;
            end
        end
    end

`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_active;
    logic          rpt_first;
    logic          rpt_due;
    logic          rpt_fire;

    assign rpt_due  = (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));
    assign rpt_fire = REPEAT_EN && rpt_active && stable && rpt_due;

    always_ff @(posedge clk) begin
        if (!reset_n || !REPEAT_EN || !stable) begin
            rpt_active <= 1'b0;
            rpt_first  <= 1'b0;
            rpt_cnt    <= '0;
        end else if (press) begin
            rpt_active <= 1'b1;
            rpt_first  <= 1'b1;
            rpt_cnt    <= '0;
        end else if (rpt_active) begin
            if (rpt_due) begin
                rpt_first <= 1'b0;
                rpt_cnt   <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    assign fire = press | rpt_fire;
`else
    assign fire = press;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= fire;
        end
    end

endmodule

// File: rtl/tetris_input_frontend.sv
// Tetris input front end: four conditioned buttons plus a free-running 8-bit LFSR.
// Define TETRIS_INPUT_AUTO_REPEAT_EN to add hold-to-repeat on down/left/right.
module tetris_input_frontend
    import tetris_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter logic [LFSR_W-1:0]  LFSR_SEED       = LFSR_SEED_DEFAULT
`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
    ,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               down_btn,
    input  logic               right_btn,
    input  logic               left_btn,
    input  logic               rotate_btn,
    output logic               down_pulse,
    output logic               right_pulse,
    output logic               left_pulse,
    output logic               rotate_pulse,
    output logic               any_pulse,
    output logic [LFSR_W-1:0]  lfsr_out,
    output logic [PIECE_W-1:0] random_piece,
    output logic [ROT_W-1:0]   random_rotate
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] pulses;
    logic [LFSR_W-1:0]  lfsr;

    assign raw = {down_btn, right_btn, left_btn, rotate_btn};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
            ,
            .REPEAT_EN       (i != BTN_ROTATE),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .btn     (raw[i]),
            .pulse   (pulses[i])
        );
    end

    assign down_pulse   = pulses[BTN_DOWN];
    assign right_pulse  = pulses[BTN_RIGHT];
    assign left_pulse   = pulses[BTN_LEFT];
    assign rotate_pulse = pulses[BTN_ROTATE];
    assign any_pulse    = |pulses;

    // The all-zero lock-up state is unreachable normally; recover from upsets.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else if (lfsr == '0) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign lfsr_out      = lfsr;
    assign random_piece  = piece_from_bits(lfsr[2:0]);
    assign random_rotate = lfsr[7:6];

endmodule

// File: tb/tb_tetris_input_frontend.sv
// Self-checking bench for tetris_input_frontend: LFSR sequence table, button
// press/glitch/reset scenarios with a pulse scoreboard, optional auto-repeat.
module tb_tetris_input_frontend;
    import tetris_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       down_btn = 1'b0;
    logic       right_btn = 1'b0;
    logic       left_btn = 1'b0;
    logic       rotate_btn = 1'b0;
    logic       down_pulse;
    logic       right_pulse;
    logic       left_pulse;
    logic       rotate_pulse;
    logic       any_pulse;
    logic [7:0] lfsr_out;
    logic [2:0] random_piece;
    logic [1:0] random_rotate;

    tetris_input_frontend #(
        .DEBOUNCE_CYCLES (DEB),
        .LFSR_SEED       (8'hE1)
`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .down_btn      (down_btn),
        .right_btn     (right_btn),
        .left_btn      (left_btn),
        .rotate_btn    (rotate_btn),
        .down_pulse    (down_pulse),
        .right_pulse   (right_pulse),
        .left_pulse    (left_pulse),
        .rotate_pulse  (rotate_pulse),
        .any_pulse     (any_pulse),
        .lfsr_out      (lfsr_out),
        .random_piece  (random_piece),
        .random_rotate (random_rotate)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entry: {absolute cycle number, {down,right,left,rotate}}
    logic [35:0] exp_q[$];

    // ---------------- pulse monitor ----------------
    always @(negedge clk) begin
        logic [35:0] head;
        logic [3:0]  exp_m;
        logic [3:0]  got_m;
        exp_m = 4'b0000;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (int'(head[35:4]) == cyc) begin
                exp_m = head[3:0];
                void'(exp_q.pop_front());
            end
        end
        got_m = {down_pulse, right_pulse, left_pulse, rotate_pulse};
        n_checks++;
        if (got_m !== exp_m) begin
            n_errors++;
            $display("FAIL pulses cyc=%0d got=%b exp=%b", cyc, got_m, exp_m);
        end
        n_checks++;
        if (any_pulse !== (|exp_m)) begin
            n_errors++;
            $display("FAIL any_pulse cyc=%0d got=%b exp=%b", cyc, any_pulse, |exp_m);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_btns(input logic [3:0] mask);
        {down_btn, right_btn, left_btn, rotate_btn} = mask;
    endtask

    // Expected pulses for a press whose edge 0 follows cycle t0; last_edge is
    // the last relative edge at which the debounced level is still high.
    task automatic push_press(input int t0, input logic [3:0] mask, input int last_edge);
        logic [3:0] rmask;
        if (DEB + 2 <= last_edge) exp_q.push_back({32'(t0 + DEB + 3), mask});
`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
        rmask = mask & 4'b1110;
        if (rmask != 4'b0000) begin
            for (int e = DEB + 2 + RD; e <= last_edge; e += RP)
                exp_q.push_back({32'(t0 + 1 + e), rmask});
        end
`else
        rmask = 4'b0000;
        if (rmask != 4'b0000) exp_q.push_back('0);
`endif
    endtask

    // Called at a negedge; hold >= DEB cycles, then release and idle for gap.
    task automatic hold_press(input logic [3:0] mask, input int hold, input int gap);
        int t0;
        set_btns(mask);
        t0 = cyc;
        push_press(t0, mask, hold + DEB + 1);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (gap) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Independent LFSR model from the polynomial taps (bits 7,5,4,3).
    function automatic logic [7:0] model_step(input logic [7:0] m);
        return {m[6:0], ^(m & 8'b1011_1000)};
    endfunction

    typedef struct {
        logic [7:0] lfsr;
        logic [2:0] piece;
        logic [1:0] rot;
    } lfsr_vec_t;

    lfsr_vec_t vecs[3];

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] m;
        logic [2:0] pm;
        int         t0;

        vecs[0] = '{8'hE1, 3'd1, 2'd3};
        vecs[1] = '{8'hC2, 3'd2, 2'd3};
        vecs[2] = '{8'h85, 3'd5, 2'd2};

        // Reset state
        reset_n = 1'b0;
        set_btns(4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check8("reset_lfsr", lfsr_out, 8'hE1);
        reset_n = 1'b1;

        // LFSR: table for the first steps, model for the full period
        m = 8'hE1;
        for (int s = 0; s <= 255; s++) begin
            if (s < 3) begin
                check8("vec_lfsr", lfsr_out, vecs[s].lfsr);
                check8("vec_piece", {5'd0, random_piece}, {5'd0, vecs[s].piece});
                check8("vec_rotate", {6'd0, random_rotate}, {6'd0, vecs[s].rot});
            end
            check8("lfsr_model", lfsr_out, m);
            pm = (m[2:0] == 3'b111) ? 3'b001 : m[2:0];
            check8("piece_model", {5'd0, random_piece}, {5'd0, pm});
            check8("rotate_model", {6'd0, random_rotate}, {6'd0, m[7:6]});
            n_checks++;
            if (lfsr_out == 8'h00) begin
                n_errors++;
                $display("FAIL lfsr_zero cyc=%0d got=%h exp=nonzero", cyc, lfsr_out);
            end
            if (s > 0 && s < 255) begin
                n_checks++;
                if (lfsr_out == 8'hE1) begin
                    n_errors++;
                    $display("FAIL lfsr_early_wrap step=%0d got=%h exp=not_e1", s, lfsr_out);
                end
            end
            if (s == 255) check8("lfsr_period", lfsr_out, 8'hE1);
            m = model_step(m);
            @(posedge clk);
            @(negedge clk);
        end

        // Left held 50 cycles: single pulse in cycle DEB+2, none on release
        hold_press(4'b0010, 50, 12);

        // Right: 3-cycle highs separated by 2-cycle lows never debounce
        for (int g = 0; g < 5; g++) begin
            right_btn = 1'b1;
            repeat (3) @(posedge clk);
            @(negedge clk);
            right_btn = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);

        // Right high for exactly DEB cycles is accepted
        hold_press(4'b0100, DEB, 12);

        // Down and rotate on the same edge
        hold_press(4'b1001, 12, 12);

        // Left held with a 3-cycle low glitch: still one press
        left_btn = 1'b1;
        t0 = cyc;
        push_press(t0, 4'b0010, 43 + DEB + 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        left_btn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        left_btn = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        left_btn = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        // Reset while left is held: no pulse until release and re-press
        left_btn = 1'b1;
        t0 = cyc;
        push_press(t0, 4'b0010, 11);
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        left_btn = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        hold_press(4'b0010, 10, 12);

`ifdef TETRIS_INPUT_AUTO_REPEAT_EN
        // Auto-repeat on down; rotate never repeats
        hold_press(4'b1000, 30, 12);
        hold_press(4'b0001, 30, 12);
`endif

        // Every expected pulse must have been consumed
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_pulses got=%0d exp=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
